// File: rtl/tdm_demux116.sv
// Serial-to-parallel TDM demultiplexer: collects 16 slot bits per frame into a word.
// Optional trailing even-parity bit per frame is enabled by defining TDM_DEMUX116_PARITY_EN.
module tdm_demux116 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_in,
    input  logic        in_valid,
    output logic [3:0]  sel,
    output logic [15:0] data_out,
    output logic        out_valid,
    output logic        busy,
    output logic        parity_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1
`ifdef TDM_DEMUX116_PARITY_EN
        ,
        S_PARITY  = 2'd2
`endif
    } state_t;

    state_t      state_r;
    logic [3:0]  sel_r;
    logic [15:0] buf_r;
    logic [15:0] buf_next_s;
    logic [15:0] data_out_r;
    logic        out_valid_r;
    logic        busy_r;
    logic        parity_err_r;

    // Buffer bit position that the current slot lands in.
    function automatic logic [3:0] slot_bit(input logic [3:0] slot);
        return MSB_FIRST ? (4'd15 - slot) : slot;
    endfunction

`ifdef TDM_DEMUX116_PARITY_EN
    // 1 when the 16 data bits plus the parity bit do not have even parity.
    function automatic logic parity_error(input logic [15:0] word, input logic pbit);
        return (^word) ^ pbit;
    endfunction
`endif

    // Buffer contents with the current slot bit merged in.
    always_comb begin
        buf_next_s = buf_r;
        buf_next_s[slot_bit(sel_r)] = data_in;
    end

    // Frame FSM, slot counter, capture buffer and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            sel_r        <= 4'd0;
            buf_r        <= 16'h0000;
            data_out_r   <= 16'h0000;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    sel_r <= 4'd0;
                    if (start) begin
                        state_r <= S_CAPTURE;
                        buf_r   <= 16'h0000;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    // A restart wins over any slot bit offered in the same cycle.
                    if (start) begin
                        sel_r <= 4'd0;
                        buf_r <= 16'h0000;
                    end else if (in_valid) begin
                        buf_r <= buf_next_s;
                        if (sel_r == 4'd15) begin
`ifdef TDM_DEMUX116_PARITY_EN
                            state_r <= S_PARITY;
`else
                            state_r     <= S_IDLE;
                            data_out_r  <= buf_next_s;
                            out_valid_r <= 1'b1;
                            sel_r       <= 4'd0;
                            busy_r      <= 1'b0;
`endif
                        end else begin
                            sel_r <= sel_r + 4'd1;
                        end
                    end else begin
                        sel_r <= sel_r;
                    end
                end
`ifdef TDM_DEMUX116_PARITY_EN
                S_PARITY: begin
                    if (start) begin
                        state_r <= S_CAPTURE;
                        sel_r   <= 4'd0;
                        buf_r   <= 16'h0000;
                    end else if (in_valid) begin
                        state_r      <= S_IDLE;
                        data_out_r   <= buf_r;
                        parity_err_r <= parity_error(buf_r, data_in);
                        out_valid_r  <= 1'b1;
                        sel_r        <= 4'd0;
                        busy_r       <= 1'b0;
                    end else begin
                        sel_r <= sel_r;
                    end
                end
`endif
                default: begin
                    state_r <= S_IDLE;
                    sel_r   <= 4'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_r;
    assign data_out  = data_out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
`ifdef TDM_DEMUX116_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux116.sv
// Directed self-checking bench for tdm_demux116 (LSB-first and MSB-first instances).
module tb_tdm_demux116;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        data_in = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  sel0, sel1;
    logic [15:0] data_out0, data_out1;
    logic        out_valid0, out_valid1;
    logic        busy0, busy1;
    logic        parity_err0, parity_err1;

    int total = 0;
    int bad = 0;
    int ov_count = 0;

    always #5 clk = ~clk;

    tdm_demux116 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_valid(in_valid),
        .sel(sel0), .data_out(data_out0), .out_valid(out_valid0), .busy(busy0),
        .parity_err(parity_err0)
    );

    tdm_demux116 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_valid(in_valid),
        .sel(sel1), .data_out(data_out1), .out_valid(out_valid1), .busy(busy1),
        .parity_err(parity_err1)
    );

    always @(posedge clk) begin
        if (out_valid0) ov_count <= ov_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        data_in  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Appends the even-parity bit when the parity feature is built in.
    task automatic close_frame(input logic [15:0] w);
`ifdef TDM_DEMUX116_PARITY_EN
        put_bit(^w);
`else
        if (w === 16'hxxxx) step();
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; data_in = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; data_in = 1'b0;
        total++; if (sel0 !== 4'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel0); end
        total++; if (data_out0 !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", data_out0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", out_valid0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        total++; if (parity_err0 !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err0); end
        step();
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy0); end
    endtask

    task automatic test_basic();
        logic [15:0] w = 16'h0001;
        begin_frame();
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy0); end
        for (int i = 0; i < 16; i++) begin
            total++; if (sel0 !== i[3:0]) begin bad++; $display("FAIL basic_sel got=%0d exp=%0d", sel0, i); end
            total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL basic_early_ov slot=%0d got=1 exp=0", i); end
            put_bit(w[i]);
        end
        close_frame(w);
        total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL basic_ov got=%b exp=1", out_valid0); end
        total++; if (data_out0 !== 16'h0001) begin bad++; $display("FAIL basic_data got=%h exp=0001", data_out0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy0); end
        total++; if (sel0 !== 4'd0) begin bad++; $display("FAIL basic_sel_end got=%0d exp=0", sel0); end
        total++; if (parity_err0 !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b exp=0", parity_err0); end
        step();
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL basic_ov_pulse got=%b exp=0", out_valid0); end
        total++; if (data_out0 !== 16'h0001) begin bad++; $display("FAIL basic_hold got=%h exp=0001", data_out0); end
    endtask

    task automatic test_stall();
        logic [15:0] w = 16'h0005;
        int ov_before;
        ov_before = ov_count;
        begin_frame();
        for (int i = 0; i < 6; i++) put_bit(w[i]);
        for (int g = 0; g < 3; g++) begin
            data_in = 1'b1;
            step();
            total++; if (sel0 !== 4'd6) begin bad++; $display("FAIL stall_sel got=%0d exp=6", sel0); end
            total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b exp=1", busy0); end
        end
        data_in = 1'b0;
        for (int i = 6; i < 16; i++) put_bit(w[i]);
        close_frame(w);
        total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL stall_ov got=%b exp=1", out_valid0); end
        total++; if (data_out0 !== 16'h0005) begin bad++; $display("FAIL stall_data got=%h exp=0005", data_out0); end
        step(); step();
        total++; if (ov_count - ov_before !== 1) begin bad++; $display("FAIL stall_ov_count got=%0d exp=1", ov_count - ov_before); end
    endtask

    task automatic test_restart();
        logic [15:0] w = 16'hA5A5;
        int ov_before;
        ov_before = ov_count;
        begin_frame();
        for (int i = 0; i < 8; i++) put_bit(1'b1);
        start = 1'b1; in_valid = 1'b1; data_in = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0; data_in = 1'b0;
        total++; if (sel0 !== 4'd0) begin bad++; $display("FAIL restart_sel got=%0d exp=0", sel0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL restart_ov got=%b exp=0", out_valid0); end
        total++; if (data_out0 !== 16'h0005) begin bad++; $display("FAIL restart_keep got=%h exp=0005", data_out0); end
        for (int i = 0; i < 16; i++) put_bit(w[i]);
        close_frame(w);
        total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL restart_ov2 got=%b exp=1", out_valid0); end
        total++; if (data_out0 !== 16'hA5A5) begin bad++; $display("FAIL restart_data got=%h exp=a5a5", data_out0); end
        step(); step();
        total++; if (ov_count - ov_before !== 1) begin bad++; $display("FAIL restart_ov_count got=%0d exp=1", ov_count - ov_before); end
    endtask

    task automatic test_reset_mid();
        int ov_before;
        begin_frame();
        for (int i = 0; i < 10; i++) put_bit(1'b1);
        total++; if (sel0 !== 4'd10) begin bad++; $display("FAIL rmid_sel_pre got=%0d exp=10", sel0); end
        ov_before = ov_count;
        rst = 1'b1; in_valid = 1'b1; data_in = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; data_in = 1'b0;
        total++; if (sel0 !== 4'd0) begin bad++; $display("FAIL rmid_sel got=%0d exp=0", sel0); end
        total++; if (data_out0 !== 16'h0000) begin bad++; $display("FAIL rmid_data got=%h exp=0000", data_out0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL rmid_ov got=%b exp=0", out_valid0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy0); end
        step(); step();
        total++; if (ov_count - ov_before !== 0) begin bad++; $display("FAIL rmid_ov_count got=%0d exp=0", ov_count - ov_before); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w1 = 16'h1234;
        logic [15:0] w2 = 16'h8001;
        begin_frame();
        for (int i = 0; i < 16; i++) put_bit(w1[i]);
        close_frame(w1);
        total++; if (data_out0 !== 16'h1234) begin bad++; $display("FAIL b2b_data1 got=%h exp=1234", data_out0); end
        total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL b2b_ov1 got=%b exp=1", out_valid0); end
        begin_frame();
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy0); end
        total++; if (sel0 !== 4'd0) begin bad++; $display("FAIL b2b_sel got=%0d exp=0", sel0); end
        for (int i = 0; i < 16; i++) put_bit(w2[i]);
        close_frame(w2);
        total++; if (data_out0 !== 16'h8001) begin bad++; $display("FAIL b2b_data2 got=%h exp=8001", data_out0); end
        total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL b2b_ov2 got=%b exp=1", out_valid0); end
        step();
    endtask

    task automatic test_msb_first();
        logic [15:0] slots = 16'h0001;
        begin_frame();
        for (int i = 0; i < 16; i++) put_bit(slots[i]);
        close_frame(slots);
        total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL msb_ov got=%b exp=1", out_valid1); end
        total++; if (data_out1 !== 16'h8000) begin bad++; $display("FAIL msb_data got=%h exp=8000", data_out1); end
        total++; if (data_out0 !== 16'h0001) begin bad++; $display("FAIL lsb_data got=%h exp=0001", data_out0); end
        step();
    endtask

    task automatic test_parity();
        logic [15:0] w = 16'h0001;
`ifdef TDM_DEMUX116_PARITY_EN
        for (int k = 0; k < 2; k++) begin
            begin_frame();
            for (int i = 0; i < 16; i++) put_bit(w[i]);
            total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL par_early_ov got=%b exp=0", out_valid0); end
            total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL par_busy got=%b exp=1", busy0); end
            put_bit(k == 0 ? 1'b1 : 1'b0);
            total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL par_ov got=%b exp=1", out_valid0); end
            total++; if (data_out0 !== 16'h0001) begin bad++; $display("FAIL par_data got=%h exp=0001", data_out0); end
            total++; if (parity_err0 !== (k == 0 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL par_err got=%b exp=%0d", parity_err0, k); end
            step();
            total++; if (parity_err0 !== (k == 0 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL par_hold got=%b exp=%0d", parity_err0, k); end
        end
`else
        begin_frame();
        for (int i = 0; i < 16; i++) put_bit(w[i]);
        total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL nopar_ov got=%b exp=1", out_valid0); end
        total++; if (parity_err0 !== 1'b0) begin bad++; $display("FAIL nopar_err got=%b exp=0", parity_err0); end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_msb_first();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux116.md
TDM_DEMUX116 -- requirements
Module: tdm_demux116

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0, which sets slot-to-bit mapping: 0 = slot k to bit k; 1 = slot k to bit 15-k.
REQ-003 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port start, input, 1 bit: frame sync; begins a new 16-slot frame.
REQ-006 Port data_in, input, 1 bit: serial slot bit, e.g. the output of an upstream 16:1 mux.
REQ-007 Port in_valid, input, 1 bit: data_in holds a valid slot bit this cycle.
REQ-008 Port sel, output, 4 bits: current slot index; drives the upstream mux select.
REQ-009 Port data_out, output, 16 bits: last completed word.
REQ-010 Port out_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-011 Port busy, output, 1 bit: high while a frame is in progress.
REQ-012 Port parity_err, output, 1 bit: parity result of the last frame; tied to 0 when the parity feature is compiled out.

Function
REQ-013 The FSM SHALL have states IDLE, CAPTURE and PARITY; PARITY exists only with the macro.
REQ-014 In IDLE, sel SHALL be 0 and busy 0; data_in and in_valid SHALL be ignored.
REQ-015 start=1 in IDLE SHALL move the FSM to CAPTURE next cycle with slot counter 0 and internal buffer cleared; data_in in that cycle SHALL NOT be captured.
REQ-016 In CAPTURE, each cycle with in_valid=1 SHALL write data_in into the buffer bit selected by sel and MSB_FIRST, then increment sel.
REQ-017 In CAPTURE, in_valid=0 SHALL stall: sel and buffer hold, with no timeout.
REQ-018 busy SHALL be 1 in CAPTURE and PARITY.
REQ-019 When slot 15 is accepted (macro off), the next cycle SHALL have data_out = full buffer including that bit, out_valid=1 for exactly one cycle, FSM in IDLE, and sel=0.
REQ-020 data_out SHALL only change on out_valid; partial words SHALL never be visible.
REQ-021 start=1 in CAPTURE or PARITY SHALL restart the frame:
- the partial word is discarded, including any bit presented that cycle;
- no out_valid is produced;
- sel is 0 next cycle.
REQ-022 start=1 on the cycle out_valid is high (FSM in IDLE) SHALL begin a new frame, giving back-to-back frames with one idle slot.
REQ-023 sel SHALL never exceed 15; there is no wrap within a frame, because the frame terminates at slot 15.

Reset
REQ-024 rst=1 SHALL override start and all other inputs.
REQ-025 On the next edge after rst=1, the block SHALL be in IDLE with sel=0, data_out=16'h0000, out_valid=0, busy=0, parity_err=0 and the buffer cleared.
REQ-026 Reset mid-frame SHALL discard the partial word with no out_valid.

Configuration
REQ-027 Macro TDM_DEMUX116_PARITY_EN SHALL control the parity feature.
- Defined: after slot 15 the FSM enters PARITY. The next in_valid=1 bit is the parity bit. out_valid fires the cycle after that bit. parity_err = XOR of the 16 data bits and the parity bit (even parity expected; 1 = error). parity_err updates with out_valid and holds until the next out_valid. Stall and restart rules apply in PARITY.
- Undefined: there is no PARITY state, out_valid follows slot 15 directly, and parity_err is constant 0.

Verification
REQ-028 Reset, start, then 16 continuous in_valid bits of 16'h0001 (LSB first) -> sel steps 0..15; out_valid is high one cycle after the 16th bit; data_out=16'h0001.
REQ-029 Frame 16'h0005 with in_valid low for 3 cycles after slot 5 -> sel holds at 6 during the gap; data_out=16'h0005; exactly one out_valid.
REQ-030 start again after 8 bits of a frame, then full frame 16'hA5A5 -> no out_valid for the aborted frame; data_out keeps its prior value, then becomes 16'hA5A5.
REQ-031 rst asserted at sel=10 -> the next cycle has all outputs 0, busy=0 and no out_valid.
REQ-032 MSB_FIRST=1, stream 1 followed by 15 zeros -> data_out=16'h8000.
REQ-033 Macro defined, frame 16'h0001 followed by parity bit 1 -> parity_err=0; the same frame with parity bit 0 -> parity_err=1; both with out_valid one cycle after the parity bit.
